wb_queue: RTL and testbench
===========================

Name: wb_queue

Overview:
- Writeback staging queue that sits directly upstream of the register bank and drives its single write port.
- Merges two result producers, the memory/load path and the ALU path, each with a valid/ready handshake.
- Buffers results in program order and presents at most one register write per cycle.
- Exports a per-register pending mask so the hazard logic can stall readers of registers with in-flight writes.

Parameters:
- DATA_WIDTH, 32, register data width.
- NUM_REG, 32, number of architectural registers.
- DEPTH, 4, queue entries; power of two, at least 2.
- SELECT_WIDTH, localparam $clog2(NUM_REG), register index width.
- COUNT_WIDTH, localparam $clog2(DEPTH+1), occupancy width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- i_mem_valid  in  1  load result valid.
- o_mem_ready  out  1  queue can accept the load result.
- i_mem_select  in  SELECT_WIDTH  load destination register.
- i_mem_data  in  DATA_WIDTH  load data.
- i_alu_valid  in  1  ALU result valid.
- o_alu_ready  out  1  queue can accept the ALU result.
- i_alu_select  in  SELECT_WIDTH  ALU destination register.
- i_alu_data  in  DATA_WIDTH  ALU data.
- o_write_enable  out  1  register bank write enable (registered).
- o_write_select  out  SELECT_WIDTH  register bank write index (registered).
- o_write_data  out  DATA_WIDTH  register bank write data (registered).
- o_pending  out  NUM_REG  bit r = 1 while a write to register r is queued or on the output.
- o_count  out  COUNT_WIDTH  queue occupancy; excludes the output register.
- o_full  out  1  o_count == DEPTH.
- o_empty  out  1  o_count == 0.

Behaviour:
- Reset (rst = 0, asynchronous):
  - read/write pointers and count go to 0;
  - o_write_enable, o_write_select and o_write_data go to 0;
  - o_pending goes to all-zero; o_empty = 1, o_full = 0.
  - Reset mid-operation discards every queued entry and the output-register entry; nothing is written after reset.
- Free slots: free = DEPTH - o_count. No credit is given for a same-cycle pop.
- Ready logic:
  - o_mem_ready = (free >= 1).
  - o_alu_ready = (free >= 2) || (free >= 1 && !i_mem_valid).
- Handshake: a transfer occurs when valid && ready at a rising edge. Producers hold select and data stable while valid && !ready.
- Ordering: when both transfer in the same cycle, the mem entry is enqueued first because the load is the older instruction. Queue order defines write order.
- Discard rule: a transfer with select == 0 or select >= NUM_REG completes its handshake but is not enqueued. It takes no slot and sets no pending bit.
- Pop, at each rising edge:
  - if o_count > 0: head moves to the output register and o_write_enable = 1;
  - otherwise o_write_enable = 0, with select and data holding their last values.
  - Push and pop in the same edge are legal; o_count changes by (pushes - pop).
- Latency:
  - an entry pushed at edge N into an empty queue is popped at edge N+1;
  - o_write_enable is high during cycle N+1..N+2;
  - the register bank captures it at edge N+2.
  - Throughput is one write per cycle sustained.
- Full: both readies are 0 and inputs stall.
  - A pop in that cycle frees a slot visible from the next cycle only.
- Wrap-around: pointers are SELECT-independent, $clog2(DEPTH) bits, and wrap naturally. The count is tracked separately, so full and empty are unambiguous.
- o_pending (combinational from state): OR over all valid queue entries and the output register (when o_write_enable = 1) of one-hot(select). Bit 0 is always 0.
- Duplicate destinations in the queue are legal; they are written in order and the last write wins.

Decomposition:
- Shared package cbl_pkg holds:
  - the wb_entry_t struct {select, data};
  - the DEPTH default;
  - a function onehot_sel(select) returning a NUM_REG-bit mask.
- One sub-module is natural: wb_fifo2w, a FIFO with two push ports (ordered) and one pop port, exposing entries for the pending-mask OR.
- wb_queue adds the ready logic, the discard filter, the output register and o_pending.

Test Plan:
- Reset, then a single mem push (select = 5, data = 0xDEAD_BEEF) at edge 1 -> o_write_enable = 1 with select 5 and data 0xDEADBEEF in cycle 2..3 only; o_pending[5] = 1 from edge 1 until edge 3.
- Simultaneous push at one edge, mem (select 3, 0x11) and alu (select 3, 0x22) -> two consecutive writes to register 3, 0x11 then 0x22; o_count peaks at 2.
- ALU push with select 0, data 0xFFFF -> handshake completes, o_count stays 0, no write, o_pending = 0.
- Both producers valid every cycle with DEPTH = 4 -> o_full asserts; o_alu_ready = 0 whenever free < 2; all accepted entries are written once, in mem-before-alu order, with no loss across pointer wrap (at least 12 entries).
- Fill 3 entries, then drive rst = 0 mid-cycle (asynchronous) -> o_write_enable, o_pending and o_count go to 0 immediately; after release, no stale writes appear.
- Queue with o_count = 3 and only mem valid -> o_mem_ready = 1, o_alu_ready = 0 if alu also valid; next edge o_count = 3 (one push, one pop).

Source files
------------

// File: rtl/cbl_pkg.sv
// Shared types and helpers for the writeback staging queue.
// The pending-mask helper covers register files of up to MAX_REG entries.
package cbl_pkg;

  localparam int DATA_WIDTH_DEF   = 32;
  localparam int NUM_REG_DEF      = 32;
  localparam int DEPTH_DEF        = 4;
  localparam int SELECT_WIDTH_DEF = $clog2(NUM_REG_DEF);

  localparam int MAX_REG          = 256;
  localparam int MAX_SELECT_WIDTH = $clog2(MAX_REG);

  typedef struct packed {
    logic [SELECT_WIDTH_DEF-1:0] select;
    logic [DATA_WIDTH_DEF-1:0]   data;
  } wb_entry_t;

  function automatic logic [MAX_REG-1:0] onehot_sel(input logic [MAX_SELECT_WIDTH-1:0] select);
    logic [MAX_REG-1:0] mask;
    mask         = '0;
    mask[select] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/wb_fifo2w.sv
// Circular FIFO with two ordered push ports (a before b) and one pop port.
// The tag field of every slot is exported together with a per-slot valid mask.
module wb_fifo2w
  import cbl_pkg::*;
#(
  parameter  int WIDTH       = SELECT_WIDTH_DEF + DATA_WIDTH_DEF,
  parameter  int TAG_WIDTH   = SELECT_WIDTH_DEF,
  parameter  int DEPTH       = DEPTH_DEF,
  localparam int PTR_WIDTH   = $clog2(DEPTH),
  localparam int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                push_a,
  input  logic [WIDTH-1:0]                    data_a,
  input  logic                                push_b,
  input  logic [WIDTH-1:0]                    data_b,
  input  logic                                pop,
  output logic [WIDTH-1:0]                    head,
  output logic [COUNT_WIDTH-1:0]              count,
  output logic [DEPTH-1:0][TAG_WIDTH-1:0]     tags,
  output logic [DEPTH-1:0]                    entry_valid
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_WIDTH-1:0]        wr_ptr;
  logic [PTR_WIDTH-1:0]        rd_ptr;
  logic [PTR_WIDTH-1:0]        wr_ptr_b;

  // Port b lands behind port a when both push in the same cycle.
  assign wr_ptr_b = push_a ? wr_ptr + PTR_WIDTH'(1) : wr_ptr;

  always_ff @(posedge clk) begin
    if (push_a) mem[wr_ptr]   <= data_a;
    if (push_b) mem[wr_ptr_b] <= data_b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_WIDTH'(push_a) + PTR_WIDTH'(push_b);
      rd_ptr <= rd_ptr + PTR_WIDTH'(pop);
      count  <= count + COUNT_WIDTH'(push_a) + COUNT_WIDTH'(push_b) - COUNT_WIDTH'(pop);
    end
  end

  assign head = mem[rd_ptr];

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    tags        = '0;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tags[i]        = mem[i][WIDTH-1 -: TAG_WIDTH];
      entry_valid[i] = COUNT_WIDTH'(PTR_WIDTH'(PTR_WIDTH'(i) - rd_ptr)) < count;
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Writeback staging queue: merges load and ALU results in program order and
// drives the register bank write port, one registered write per cycle.
module wb_queue
  import cbl_pkg::*;
#(
  parameter  int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter  int NUM_REG      = NUM_REG_DEF,
  parameter  int DEPTH        = DEPTH_DEF,
  localparam int SELECT_WIDTH = $clog2(NUM_REG),
  localparam int COUNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_mem_valid,
  output logic                    o_mem_ready,
  input  logic [SELECT_WIDTH-1:0] i_mem_select,
  input  logic [DATA_WIDTH-1:0]   i_mem_data,
  input  logic                    i_alu_valid,
  output logic                    o_alu_ready,
  input  logic [SELECT_WIDTH-1:0] i_alu_select,
  input  logic [DATA_WIDTH-1:0]   i_alu_data,
  output logic                    o_write_enable,
  output logic [SELECT_WIDTH-1:0] o_write_select,
  output logic [DATA_WIDTH-1:0]   o_write_data,
  output logic [NUM_REG-1:0]      o_pending,
  output logic [COUNT_WIDTH-1:0]  o_count,
  output logic                    o_full,
  output logic                    o_empty
);

  localparam int ENTRY_WIDTH = SELECT_WIDTH + DATA_WIDTH;

  logic [COUNT_WIDTH-1:0]               count;
  logic [COUNT_WIDTH-1:0]               free;
  logic                                 mem_push;
  logic                                 alu_push;
  logic                                 pop;
  logic [ENTRY_WIDTH-1:0]               head;
  logic [SELECT_WIDTH-1:0]              head_select;
  logic [DATA_WIDTH-1:0]                head_data;
  logic [DEPTH-1:0][SELECT_WIDTH-1:0]   tags;
  logic [DEPTH-1:0]                     entry_valid;

  function automatic logic writable(input logic [SELECT_WIDTH-1:0] select);
    return (select != '0) && (int'(select) < NUM_REG);
  endfunction

  // Readiness ignores a same-cycle pop so it depends only on registered state.
  assign free        = COUNT_WIDTH'(DEPTH) - count;
  assign o_mem_ready = free >= COUNT_WIDTH'(1);
  assign o_alu_ready = (free >= COUNT_WIDTH'(2)) || ((free >= COUNT_WIDTH'(1)) && !i_mem_valid);

  // Writes to r0 or past the register file still handshake but are dropped here.
  assign mem_push = i_mem_valid && o_mem_ready && writable(i_mem_select);
  assign alu_push = i_alu_valid && o_alu_ready && writable(i_alu_select);
  assign pop      = count != '0;

  wb_fifo2w #(
    .WIDTH     (ENTRY_WIDTH),
    .TAG_WIDTH (SELECT_WIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_a      (mem_push),
    .data_a      ({i_mem_select, i_mem_data}),
    .push_b      (alu_push),
    .data_b      ({i_alu_select, i_alu_data}),
    .pop         (pop),
    .head        (head),
    .count       (count),
    .tags        (tags),
    .entry_valid (entry_valid)
  );

  assign {head_select, head_data} = head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_write_enable <= 1'b0;
      o_write_select <= '0;
      o_write_data   <= '0;
    end else if (pop) begin
      o_write_enable <= 1'b1;
      o_write_select <= head_select;
      o_write_data   <= head_data;
    end else begin
      o_write_enable <= 1'b0;
    end
  end

  always_comb begin
    o_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) o_pending |= NUM_REG'(onehot_sel(MAX_SELECT_WIDTH'(tags[i])));
    end
    if (o_write_enable) o_pending |= NUM_REG'(onehot_sel(MAX_SELECT_WIDTH'(o_write_select)));
    o_pending[0] = 1'b0;
  end

  assign o_count = count;
  assign o_full  = count == COUNT_WIDTH'(DEPTH);
  assign o_empty = count == '0;

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue against a queue-based reference model.
module tb_wb_queue;
  import cbl_pkg::*;

  localparam int DW    = 32;
  localparam int NR    = 32;
  localparam int DEPTH = 4;
  localparam int SW    = 5;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_mem_valid;
  logic          o_mem_ready;
  logic [SW-1:0] i_mem_select;
  logic [DW-1:0] i_mem_data;
  logic          i_alu_valid;
  logic          o_alu_ready;
  logic [SW-1:0] i_alu_select;
  logic [DW-1:0] i_alu_data;
  logic          o_write_enable;
  logic [SW-1:0] o_write_select;
  logic [DW-1:0] o_write_data;
  logic [NR-1:0] o_pending;
  logic [CW-1:0] o_count;
  logic          o_full;
  logic          o_empty;

  wb_queue #(.DATA_WIDTH(DW), .NUM_REG(NR), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .i_mem_valid(i_mem_valid), .o_mem_ready(o_mem_ready),
    .i_mem_select(i_mem_select), .i_mem_data(i_mem_data),
    .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
    .i_alu_select(i_alu_select), .i_alu_data(i_alu_data),
    .o_write_enable(o_write_enable), .o_write_select(o_write_select),
    .o_write_data(o_write_data), .o_pending(o_pending),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queued results in program order plus the write-port contents.
  wb_entry_t     mq[$];
  logic          m_we;
  logic [SW-1:0] m_sel;
  logic [DW-1:0] m_data;
  bit            last_mem_fire;
  bit            last_alu_fire;

  function automatic int model_free();
    return DEPTH - mq.size();
  endfunction

  function automatic bit model_mem_ready();
    return model_free() >= 1;
  endfunction

  function automatic bit model_alu_ready(input bit mem_v);
    return (model_free() >= 2) || (model_free() >= 1 && !mem_v);
  endfunction

  function automatic logic [NR-1:0] model_pending();
    logic [NR-1:0] p;
    p = '0;
    foreach (mq[i]) p[mq[i].select] = 1'b1;
    if (m_we) p[m_sel] = 1'b1;
    return p;
  endfunction

  function automatic bit keeps(input logic [SW-1:0] s);
    return (s != 0) && (int'(s) < NR);
  endfunction

  task automatic advance();
    bit        fm, fa;
    wb_entry_t e;
    fm = i_mem_valid && model_mem_ready();
    fa = i_alu_valid && model_alu_ready(i_mem_valid);
    @(posedge clk);
    if (mq.size() > 0) begin
      e      = mq.pop_front();
      m_we   = 1'b1;
      m_sel  = e.select;
      m_data = e.data;
    end else begin
      m_we = 1'b0;
    end
    if (fm && keeps(i_mem_select)) begin
      e.select = i_mem_select; e.data = i_mem_data; mq.push_back(e);
    end
    if (fa && keeps(i_alu_select)) begin
      e.select = i_alu_select; e.data = i_alu_data; mq.push_back(e);
    end
    last_mem_fire = fm;
    last_alu_fire = fa;
    #1;
  endtask

  task automatic idle_inputs();
    i_mem_valid = 1'b0; i_mem_select = '0; i_mem_data = '0;
    i_alu_valid = 1'b0; i_alu_select = '0; i_alu_data = '0;
  endtask

  task automatic model_clear();
    mq.delete();
    m_we = 1'b0; m_sel = '0; m_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    model_clear();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (o_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b want 0", o_write_enable); end
    n_checks++; if (o_write_select !== '0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", o_write_select); end
    n_checks++; if (o_write_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", o_write_data); end
    n_checks++; if (o_pending !== '0) begin n_fail++; $display("FAIL reset_pending: got %h want 0", o_pending); end
    n_checks++; if (o_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", o_count); end
    n_checks++; if (o_empty !== 1'b1 || o_full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got empty=%0b full=%0b want 1/0", o_empty, o_full); end
    n_checks++; if (o_mem_ready !== 1'b1 || o_alu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b/%0b want 1/1", o_mem_ready, o_alu_ready); end
  endtask

  task automatic test_single();
    do_reset();
    i_mem_valid = 1'b1; i_mem_select = 5'd5; i_mem_data = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (o_mem_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %0b want 1", o_mem_ready); end
    advance();
    idle_inputs();
    n_checks++; if (o_write_enable !== 1'b0) begin n_fail++; $display("FAIL single_we_c1: got %0b want 0", o_write_enable); end
    n_checks++; if (o_pending !== 32'h20) begin n_fail++; $display("FAIL single_pend_c1: got %h want 00000020", o_pending); end
    n_checks++; if (o_count !== 3'd1) begin n_fail++; $display("FAIL single_count_c1: got %0d want 1", o_count); end
    advance();
    n_checks++; if (o_write_enable !== 1'b1 || o_write_select !== 5'd5 || o_write_data !== 32'hDEAD_BEEF)
      begin n_fail++; $display("FAIL single_write_c2: got we=%0b sel=%0d data=%h want 1/5/deadbeef", o_write_enable, o_write_select, o_write_data); end
    n_checks++; if (o_pending !== 32'h20) begin n_fail++; $display("FAIL single_pend_c2: got %h want 00000020", o_pending); end
    n_checks++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL single_count_c2: got %0d want 0", o_count); end
    advance();
    n_checks++; if (o_write_enable !== 1'b0) begin n_fail++; $display("FAIL single_we_c3: got %0b want 0", o_write_enable); end
    n_checks++; if (o_pending !== '0) begin n_fail++; $display("FAIL single_pend_c3: got %h want 0", o_pending); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    i_mem_valid = 1'b1; i_mem_select = 5'd3; i_mem_data = 32'h11;
    i_alu_valid = 1'b1; i_alu_select = 5'd3; i_alu_data = 32'h22;
    advance();
    idle_inputs();
    n_checks++; if (o_count !== 3'd2) begin n_fail++; $display("FAIL same_count: got %0d want 2", o_count); end
    advance();
    n_checks++; if (o_write_enable !== 1'b1 || o_write_select !== 5'd3 || o_write_data !== 32'h11)
      begin n_fail++; $display("FAIL same_first: got we=%0b sel=%0d data=%h want 1/3/11", o_write_enable, o_write_select, o_write_data); end
    advance();
    n_checks++; if (o_write_enable !== 1'b1 || o_write_select !== 5'd3 || o_write_data !== 32'h22)
      begin n_fail++; $display("FAIL same_second: got we=%0b sel=%0d data=%h want 1/3/22", o_write_enable, o_write_select, o_write_data); end
    advance();
    n_checks++; if (o_write_enable !== 1'b0 || o_pending !== '0)
      begin n_fail++; $display("FAIL same_done: got we=%0b pend=%h want 0/0", o_write_enable, o_pending); end
  endtask

  task automatic test_discard();
    do_reset();
    i_alu_valid = 1'b1; i_alu_select = 5'd0; i_alu_data = 32'hFFFF;
    #1;
    n_checks++; if (o_alu_ready !== 1'b1) begin n_fail++; $display("FAIL discard_ready: got %0b want 1", o_alu_ready); end
    advance();
    idle_inputs();
    n_checks++; if (o_count !== 3'd0 || o_pending !== '0)
      begin n_fail++; $display("FAIL discard_state: got count=%0d pend=%h want 0/0", o_count, o_pending); end
    advance();
    n_checks++; if (o_write_enable !== 1'b0) begin n_fail++; $display("FAIL discard_we: got %0b want 0", o_write_enable); end
  endtask

  task automatic test_stream();
    bit mem_hold = 0;
    bit alu_hold = 0;
    int writes   = 0;
    do_reset();
    for (int c = 0; c < 80; c++) begin
      if (!mem_hold) begin
        i_mem_valid  = (c < 30) ? 1'b1 : 1'($urandom_range(0, 1));
        i_mem_select = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, NR - 1));
        i_mem_data   = $urandom;
      end
      if (!alu_hold) begin
        i_alu_valid  = (c < 30) ? 1'b1 : 1'($urandom_range(0, 1));
        i_alu_select = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, NR - 1));
        i_alu_data   = $urandom;
      end
      #1;
      n_checks++; if (o_mem_ready !== model_mem_ready() || o_alu_ready !== model_alu_ready(i_mem_valid))
        begin n_fail++; $display("FAIL stream_ready c%0d: got %0b/%0b want %0b/%0b", c, o_mem_ready, o_alu_ready, model_mem_ready(), model_alu_ready(i_mem_valid)); end
      advance();
      mem_hold = i_mem_valid && !last_mem_fire;
      alu_hold = i_alu_valid && !last_alu_fire;
      if (o_write_enable === 1'b1) writes++;
      n_checks++; if (o_write_enable !== m_we || o_write_select !== m_sel || o_write_data !== m_data)
        begin n_fail++; $display("FAIL stream_write c%0d: got %0b/%0d/%h want %0b/%0d/%h", c, o_write_enable, o_write_select, o_write_data, m_we, m_sel, m_data); end
      n_checks++; if (int'(o_count) !== mq.size() || o_pending !== model_pending())
        begin n_fail++; $display("FAIL stream_state c%0d: got count=%0d pend=%h want %0d/%h", c, o_count, o_pending, mq.size(), model_pending()); end
      n_checks++; if (o_full !== (mq.size() == DEPTH) || o_empty !== (mq.size() == 0))
        begin n_fail++; $display("FAIL stream_flags c%0d: got full=%0b empty=%0b want %0b/%0b", c, o_full, o_empty, mq.size() == DEPTH, mq.size() == 0); end
    end
    idle_inputs();
    for (int c = 0; c < 8; c++) begin
      advance();
      if (o_write_enable === 1'b1) writes++;
      n_checks++; if (o_write_enable !== m_we || o_write_select !== m_sel || o_write_data !== m_data)
        begin n_fail++; $display("FAIL drain_write c%0d: got %0b/%0d/%h want %0b/%0d/%h", c, o_write_enable, o_write_select, o_write_data, m_we, m_sel, m_data); end
    end
    n_checks++; if (o_empty !== 1'b1 || o_pending !== '0)
      begin n_fail++; $display("FAIL drain_empty: got empty=%0b pend=%h want 1/0", o_empty, o_pending); end
    n_checks++; if (writes < 12) begin n_fail++; $display("FAIL stream_volume: got %0d writes want at least 12", writes); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_mem_valid = 1'b1; i_mem_select = 5'd7; i_mem_data = 32'h1;
    i_alu_valid = 1'b1; i_alu_select = 5'd8; i_alu_data = 32'h2;
    advance();
    i_mem_select = 5'd9;  i_mem_data = 32'h3;
    i_alu_select = 5'd10; i_alu_data = 32'h4;
    advance();
    idle_inputs();
    n_checks++; if (o_count !== 3'd3) begin n_fail++; $display("FAIL midrst_fill: got %0d want 3", o_count); end
    #2 rst = 1'b0;
    model_clear();
    #1;
    n_checks++; if (o_write_enable !== 1'b0 || o_pending !== '0 || o_count !== '0 || o_empty !== 1'b1)
      begin n_fail++; $display("FAIL midrst_clear: got we=%0b pend=%h count=%0d empty=%0b want 0/0/0/1", o_write_enable, o_pending, o_count, o_empty); end
    #3 rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      advance();
      n_checks++; if (o_write_enable !== 1'b0 || o_pending !== '0)
        begin n_fail++; $display("FAIL midrst_stale c%0d: got we=%0b pend=%h want 0/0", c, o_write_enable, o_pending); end
    end
  endtask

  task automatic test_count3();
    do_reset();
    i_mem_valid = 1'b1; i_mem_select = 5'd4; i_mem_data = 32'h40;
    i_alu_valid = 1'b1; i_alu_select = 5'd5; i_alu_data = 32'h50;
    advance();
    i_mem_select = 5'd6; i_mem_data = 32'h60;
    i_alu_select = 5'd7; i_alu_data = 32'h70;
    advance();
    i_alu_valid = 1'b0;
    i_mem_select = 5'd11; i_mem_data = 32'hB0;
    #1;
    n_checks++; if (o_count !== 3'd3 || o_mem_ready !== 1'b1)
      begin n_fail++; $display("FAIL c3_mem_ready: got count=%0d ready=%0b want 3/1", o_count, o_mem_ready); end
    i_alu_valid = 1'b1; i_alu_select = 5'd12; i_alu_data = 32'hC0;
    #1;
    n_checks++; if (o_mem_ready !== 1'b1 || o_alu_ready !== 1'b0)
      begin n_fail++; $display("FAIL c3_alu_ready: got %0b/%0b want 1/0", o_mem_ready, o_alu_ready); end
    advance();
    idle_inputs();
    n_checks++; if (o_count !== 3'd3) begin n_fail++; $display("FAIL c3_count: got %0d want 3", o_count); end
    n_checks++; if (o_write_enable !== 1'b1 || o_write_select !== 5'd5 || o_write_data !== 32'h50)
      begin n_fail++; $display("FAIL c3_write: got %0b/%0d/%h want 1/5/50", o_write_enable, o_write_select, o_write_data); end
    for (int c = 0; c < 5; c++) begin
      advance();
      n_checks++; if (o_write_enable !== m_we || o_write_select !== m_sel || o_write_data !== m_data)
        begin n_fail++; $display("FAIL c3_drain c%0d: got %0b/%0d/%h want %0b/%0d/%h", c, o_write_enable, o_write_select, o_write_data, m_we, m_sel, m_data); end
    end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    model_clear();
    test_reset();
    test_single();
    test_same_cycle();
    test_discard();
    test_stream();
    test_reset_mid();
    test_count3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
